snoop_initiator: RTL
====================

Name: snoop_initiator

Overview:
Interconnect-side master of the ACE snoop channels; drives one cache L1's snoop port on behalf of another master's coherent request. Accepts one snoop command from the coherence arbiter, issues it on AC, collects the CR response, and receives the CD cache-line burst when DataTransfer is set. Forwards each data word into the interconnect line buffer, then returns a one-cycle completion with the decoded response to the arbiter.

Parameters:
ADDR_WIDTH, 32, snoop address width
DATA_WIDTH, 32, CD data word width
LINE_WORDS, 16, words per cache line (CD beats per transfer)

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset; asynchronous and active-low
req_valid  in  1  arbiter snoop request
req_ready  out  1  initiator idle, accepting request
req_snoop  in  4  snoop type: 0001 ReadShared, 0111 ReadUnique, 1101 MakeInvalid
req_addr  in  ADDR_WIDTH  line address
req_prot  in  3  protection attributes
ACVALID  out  1  AC valid
ACREADY  in  1  AC ready
ACADDR  out  ADDR_WIDTH  snoop address
ACSNOOP  out  4  snoop type
ACPROT  out  3  protection
CRVALID  in  1  CR valid
CRREADY  out  1  CR ready
CRRESP  in  5  [0]DataTransfer [1]Error [2]PassDirty [3]IsShared [4]WasUnique
CDVALID  in  1  CD valid
CDREADY  out  1  CD ready
CDDATA  in  DATA_WIDTH  CD data word
CDLAST  in  1  CD last beat
buf_ready  in  1  line buffer can accept a word
buf_wr_en  out  1  write word to line buffer
buf_wr_idx  out  log2(LINE_WORDS)  word index 0..LINE_WORDS-1
buf_wr_data  out  DATA_WIDTH  word
done  out  1  one-cycle completion pulse
done_resp  out  5  registered CRRESP of completed snoop
done_has_data  out  1  line was received in buffer
done_err  out  1  CRRESP[1] set, or CDLAST protocol violation

Behaviour:
- Reset (async assert, sync release): state IDLE; ACVALID, CRREADY, CDREADY, buf_wr_en, done, done_has_data, done_err = 0; ACADDR, ACSNOOP, ACPROT, done_resp, beat counter = 0; req_ready = 1.
- States: IDLE, AC_SEND, CR_WAIT, CD_RECV, DONE.
- IDLE: req_ready=1. On req_valid: register addr/snoop/prot into AC outputs, go AC_SEND. req_ready=0 in every other state.
- AC_SEND: ACVALID=1, AC payload stable until ACVALID&&ACREADY; then CR_WAIT. ACVALID never drops before the handshake. ACREADY asserted before ACVALID is ignored.
- CR_WAIT: CRREADY=1. On CRVALID: latch CRRESP into done_resp. Go CD_RECV if CRRESP[0]=1 and ACSNOOP!=1101; otherwise go DONE. DataTransfer=1 on MakeInvalid → set done_err, go DONE, no CD beats accepted.
- CD_RECV: CDREADY = buf_ready. Beat accepted when CDVALID&&CDREADY; buf_wr_en is combinational on acceptance, buf_wr_idx = beat counter, buf_wr_data = CDDATA. Counter increments per accepted beat and saturates at LINE_WORDS-1.
- Last beat is the beat with counter == LINE_WORDS-1. Exit to DONE on accepting it. CDLAST must match it. CDLAST early → done_err=1, exit to DONE on that beat. CDLAST missing on the last beat → done_err=1, still exit.
- DONE: done=1 for exactly one cycle. done_has_data=1 iff CD_RECV was entered. done_err includes CRRESP[1]. Then IDLE. done_resp/done_has_data/done_err hold until the next request is accepted.
- Latency, with zero-wait slave: req accept → ACVALID next cycle; CR latch → done 1 cycle later (no data) or LINE_WORDS+1 cycles later (data).
- Reset mid-operation: immediate return to IDLE; all outputs return to reset values; any partial line is discarded (done is not pulsed).
- Only one outstanding snoop; no new request is accepted before done.

Decomposition:
- Shared package ace_snoop_pkg holds:
  - ACSNOOP encodings: READ_SHARED=4'b0001, READ_UNIQUE=4'b0111, MAKE_INVALID=4'b1101.
  - CRRESP bit indices: DT=0, ERR=1, PD=2, IS=3, WU=4.
  - State enum.
- This package is shared with the L1 snoop-responder side.
- No sub-module needed. The beat counter is in-line.

Test Plan:
- ReadShared, addr 0x1000; ACREADY one cycle after ACVALID; CRRESP=5'b01101; 16 beats of CDDATA=0xA0..0xAF, CDLAST on beat 15 → buf_wr_idx 0..15 with matching data; done_resp=01101, done_has_data=1, done_err=0.
- MakeInvalid, addr 0x2040; CRRESP=5'b10000 → no CDREADY; done 1 cycle after CR handshake; done_has_data=0.
- ReadUnique miss (CRRESP=0) with ACREADY delayed 5 cycles → ACVALID held and ACADDR stable for all 6 cycles; done_has_data=0.
- buf_ready toggled every other cycle during CD → CDREADY follows buf_ready; exactly 16 writes, indices gap-free.
- CDLAST asserted on beat 7 → exit after beat 7; done_err=1; 8 buffer writes.
- ARESETn pulsed low during beat 9 → ACVALID/CRREADY/CDREADY=0 immediately, no done pulse; next request completes normally.

Source files
------------

// File: rtl/ace_snoop_pkg.sv
// Shared ACE snoop-channel definitions, used by both the interconnect-side
// snoop initiator and the L1 snoop-responder.
package ace_snoop_pkg;

    localparam logic [3:0] READ_SHARED  = 4'b0001;
    localparam logic [3:0] READ_UNIQUE  = 4'b0111;
    localparam logic [3:0] MAKE_INVALID = 4'b1101;

    // CRRESP bit positions
    localparam int DT  = 0;
    localparam int ERR = 1;
    localparam int PD  = 2;
    localparam int IS  = 3;
    localparam int WU  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        AC_SEND = 3'd1,
        CR_WAIT = 3'd2,
        CD_RECV = 3'd3,
        DONE    = 3'd4
    } snoop_state_e;

    // A line follows on CD only if the responder set DataTransfer on a snoop
    // that is allowed to carry data.
    function automatic logic cr_expects_data(input logic [4:0] resp, input logic [3:0] snoop);
        return resp[DT] && (snoop != MAKE_INVALID);
    endfunction

endpackage

// File: rtl/snoop_initiator.sv
// Interconnect-side ACE snoop master: issues one snoop on AC, collects CR,
// streams any CD line into the line buffer and reports completion.
//
// state   | meaning
// IDLE    | waiting for an arbiter request (req_ready=1)
// AC_SEND | ACVALID held with stable payload until ACREADY
// CR_WAIT | CRREADY=1, waiting for the snoop response
// CD_RECV | accepting CD beats into the line buffer (CDREADY=buf_ready)
// DONE    | one-cycle completion pulse to the arbiter
module snoop_initiator
    import ace_snoop_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 16,
    localparam int IDX_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_snoop,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_prot,

    output logic                  ACVALID,
    input  logic                  ACREADY,
    output logic [ADDR_WIDTH-1:0] ACADDR,
    output logic [3:0]            ACSNOOP,
    output logic [2:0]            ACPROT,

    input  logic                  CRVALID,
    output logic                  CRREADY,
    input  logic [4:0]            CRRESP,

    input  logic                  CDVALID,
    output logic                  CDREADY,
    input  logic [DATA_WIDTH-1:0] CDDATA,
    input  logic                  CDLAST,

    input  logic                  buf_ready,
    output logic                  buf_wr_en,
    output logic [IDX_W-1:0]      buf_wr_idx,
    output logic [DATA_WIDTH-1:0] buf_wr_data,

    output logic                  done,
    output logic [4:0]            done_resp,
    output logic                  done_has_data,
    output logic                  done_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    snoop_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] ac_addr_q;
    logic [3:0]            ac_snoop_q;
    logic [2:0]            ac_prot_q;
    logic [4:0]            done_resp_q;
    logic                  done_has_data_q;
    logic                  done_err_q;
    logic [IDX_W-1:0]      beat_cnt_q;

    logic                  beat_accept;
    logic                  beat_is_last;

    assign beat_is_last = (beat_cnt_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        ACVALID     = 1'b0;
        CRREADY     = 1'b0;
        CDREADY     = 1'b0;
        buf_wr_en   = 1'b0;
        beat_accept = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = AC_SEND;
            end
            AC_SEND: begin
                ACVALID = 1'b1;
                if (ACREADY) state_d = CR_WAIT;
            end
            CR_WAIT: begin
                CRREADY = 1'b1;
                if (CRVALID) state_d = cr_expects_data(CRRESP, ac_snoop_q) ? CD_RECV : DONE;
            end
            CD_RECV: begin
                CDREADY     = buf_ready;
                beat_accept = CDVALID && buf_ready;
                buf_wr_en   = beat_accept;
                // An early CDLAST still ends the transfer on that beat.
                if (beat_accept && (beat_is_last || CDLAST)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q         <= IDLE;
            ac_addr_q       <= '0;
            ac_snoop_q      <= '0;
            ac_prot_q       <= '0;
            done_resp_q     <= '0;
            done_has_data_q <= 1'b0;
            done_err_q      <= 1'b0;
            beat_cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        ac_addr_q       <= req_addr;
                        ac_snoop_q      <= req_snoop;
                        ac_prot_q       <= req_prot;
                        done_resp_q     <= '0;
                        done_has_data_q <= 1'b0;
                        done_err_q      <= 1'b0;
                        beat_cnt_q      <= '0;
                    end
                end
                CR_WAIT: begin
                    if (CRVALID) begin
                        done_resp_q     <= CRRESP;
                        done_has_data_q <= cr_expects_data(CRRESP, ac_snoop_q);
                        // DataTransfer on MakeInvalid is a responder protocol error.
                        done_err_q      <= CRRESP[ERR] ||
                                           (CRRESP[DT] && (ac_snoop_q == MAKE_INVALID));
                    end
                end
                CD_RECV: begin
                    if (beat_accept) begin
                        if (!beat_is_last) beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (CDLAST != beat_is_last) done_err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ACADDR        = ac_addr_q;
    assign ACSNOOP       = ac_snoop_q;
    assign ACPROT        = ac_prot_q;
    assign buf_wr_idx    = beat_cnt_q;
    assign buf_wr_data   = CDDATA;
    assign done_resp     = done_resp_q;
    assign done_has_data = done_has_data_q;
    assign done_err      = done_err_q;

endmodule
